// File: rtl/cnn_acc_ci_tile.sv
// Input-channel tile accumulator: multiply/reduce one CI_PAR x KX x KY beat, accumulate over passes,
// then add bias, saturate and present one result. Define CNN_ACC_RELU_EN to clamp negative results to 0.
module cnn_acc_ci_tile #(
  parameter int CI_PAR  = 4,
  parameter int KX      = 3,
  parameter int KY      = 3,
  parameter int W_BW    = 8,
  parameter int I_F_BW  = 8,
  parameter int PASS_BW = 4,
  parameter int B_BW    = 16,
  parameter int O_BW    = 24
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             i_soft_reset,
  input  logic [PASS_BW-1:0]               i_cfg_num_pass,
  input  logic [B_BW-1:0]                  i_bias,
  input  logic                             i_in_valid,
  output logic                             o_in_ready,
  input  logic [CI_PAR*KX*KY*W_BW-1:0]     i_cnn_weight,
  input  logic [CI_PAR*KX*KY*I_F_BW-1:0]   i_in_fmap,
  output logic                             o_ot_valid,
  input  logic                             i_ot_ready,
  output logic [O_BW-1:0]                  o_ot_acc,
  output logic                             o_busy
);

  localparam int NE     = CI_PAR * KX * KY;
  localparam int P_BW   = W_BW + I_F_BW + 1;
  localparam int M_BW   = P_BW + $clog2(NE);
  localparam int ACC_BW = M_BW + PASS_BW;
  localparam int MAX_AB = (ACC_BW > B_BW) ? ACC_BW : B_BW;
  localparam int SUM_BW = ((MAX_AB > O_BW) ? MAX_AB : O_BW) + 1;

  localparam logic signed [SUM_BW-1:0] O_MAX = {{(SUM_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
  localparam logic signed [SUM_BW-1:0] O_MIN = {{(SUM_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

  state_t                    state;
  logic                      ready_reg;
  logic                      valid_reg;
  logic                      busy_reg;
  logic [O_BW-1:0]           result_reg;
  logic [PASS_BW-1:0]        pass_cnt;
  logic [PASS_BW-1:0]        num_pass_reg;
  logic signed [B_BW-1:0]    bias_reg;
  logic signed [M_BW-1:0]    r_mac;
  logic signed [ACC_BW-1:0]  r_acc;
  logic                      mac_vld;
  logic                      mac_first;

  // Element products: weight is signed, fmap is zero-extended to a positive signed value.
  logic signed [P_BW-1:0] prod [NE];

  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_mul
      logic signed [P_BW-1:0] w_ext;
      logic signed [P_BW-1:0] f_ext;
      assign w_ext = {{(P_BW-W_BW){i_cnn_weight[gi*W_BW+W_BW-1]}}, i_cnn_weight[gi*W_BW +: W_BW]};
      assign f_ext = {{(P_BW-I_F_BW){1'b0}}, i_in_fmap[gi*I_F_BW +: I_F_BW]};
      assign prod[gi] = w_ext * f_ext;
    end
  endgenerate

  logic signed [M_BW-1:0] mac_sum;

  always_comb begin
    mac_sum = '0;
    for (int k = 0; k < NE; k++) begin
      mac_sum = mac_sum + {{(M_BW-P_BW){prod[k][P_BW-1]}}, prod[k]};
    end
  end

  logic signed [ACC_BW-1:0] mac_ext;
  logic signed [ACC_BW-1:0] acc_next;
  logic signed [SUM_BW-1:0] sum_full;
  logic signed [O_BW-1:0]   sat_val;
  logic [O_BW-1:0]          result_next;

  assign mac_ext  = {{PASS_BW{r_mac[M_BW-1]}}, r_mac};
  assign acc_next = mac_first ? mac_ext : (r_acc + mac_ext);
  assign sum_full = {{(SUM_BW-ACC_BW){acc_next[ACC_BW-1]}}, acc_next}
                  + {{(SUM_BW-B_BW){bias_reg[B_BW-1]}}, bias_reg};

  always_comb begin
    if (sum_full > O_MAX) begin
      sat_val = O_MAX[O_BW-1:0];
    end else if (sum_full < O_MIN) begin
      sat_val = O_MIN[O_BW-1:0];
    end else begin
      sat_val = sum_full[O_BW-1:0];
    end
  end

`ifdef CNN_ACC_RELU_EN
  assign result_next = sat_val[O_BW-1] ? '0 : sat_val;
`else
  assign result_next = sat_val;
`endif

  logic                 accept;
  logic [PASS_BW-1:0]   cfg_pass;
  logic [PASS_BW:0]     cnt_inc;
  logic                 last_beat;

  assign accept    = i_in_valid & ready_reg;
  assign cfg_pass  = (i_cfg_num_pass == '0) ? PASS_BW'(1) : i_cfg_num_pass;
  assign cnt_inc   = {1'b0, pass_cnt} + (PASS_BW+1)'(1);
  // In IDLE the tile length comes straight from the config port; afterwards from the latched copy.
  assign last_beat = (state == IDLE) ? (cfg_pass == PASS_BW'(1))
                                     : (cnt_inc == {1'b0, num_pass_reg});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready_reg    <= 1'b0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      result_reg   <= '0;
      pass_cnt     <= '0;
      num_pass_reg <= '0;
      bias_reg     <= '0;
      r_mac        <= '0;
      r_acc        <= '0;
      mac_vld      <= 1'b0;
      mac_first    <= 1'b0;
    end else if (i_soft_reset) begin
      state        <= IDLE;
      ready_reg    <= 1'b1;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      result_reg   <= '0;
      pass_cnt     <= '0;
      num_pass_reg <= '0;
      bias_reg     <= '0;
      r_mac        <= '0;
      r_acc        <= '0;
      mac_vld      <= 1'b0;
      mac_first    <= 1'b0;
    end else begin
      mac_vld   <= accept;
      mac_first <= accept && (state == IDLE);
      if (accept) begin
        r_mac <= mac_sum;
      end
      if (mac_vld) begin
        r_acc <= acc_next;
      end

      case (state)
        IDLE: begin
          ready_reg <= 1'b1;
          if (accept) begin
            pass_cnt     <= PASS_BW'(1);
            num_pass_reg <= cfg_pass;
            bias_reg     <= i_bias;
            busy_reg     <= 1'b1;
            if (last_beat) begin
              state     <= DRAIN;
              ready_reg <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            pass_cnt <= cnt_inc[PASS_BW-1:0];
            if (last_beat) begin
              state     <= DRAIN;
              ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The final product reaches stage 2 this cycle; fold it in and latch the result.
          result_reg <= result_next;
          valid_reg  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (i_ot_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            pass_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = ready_reg;
  assign o_ot_valid = valid_reg;
  assign o_ot_acc   = result_reg;
  assign o_busy     = busy_reg;

endmodule
